// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared ALU control encoding used by both the ALU control decoder and the
// execute-stage unit, so that the two ends of the control path agree on one
// code table. Also provides a legality check for incoming control codes.
// No ports (package).
// -----------------------------------------------------------------------------
package alu_pkg;

  localparam logic [3:0] ALU_CTL_AND     = 4'd0;
  localparam logic [3:0] ALU_CTL_OR      = 4'd1;
  localparam logic [3:0] ALU_CTL_ADD     = 4'd2;
  localparam logic [3:0] ALU_CTL_SUB     = 4'd6;
  localparam logic [3:0] ALU_CTL_INVALID = 4'd15;

  // True only for the four operations the execute unit implements.
  function automatic logic alu_ctl_is_legal(input logic [3:0] ctl);
    logic legal;
    case (ctl)
      ALU_CTL_AND,
      ALU_CTL_OR,
      ALU_CTL_ADD,
      ALU_CTL_SUB: legal = 1'b1;
      default:     legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/alu_core.sv
// -----------------------------------------------------------------------------
// alu_core
// Purely combinational ALU datapath evaluated in the result stage.
// Ports:
//   ctl     in   4     ALU control code (alu_pkg encoding)
//   a, b    in   XLEN  operands
//   result  out  XLEN  AND/OR bitwise, ADD/SUB wrapping; 0 for illegal codes
//   zero    out  1     result == 0 for legal codes, forced 0 for illegal codes
//   illegal out  1     ctl is not one of the implemented operations
// -----------------------------------------------------------------------------
module alu_core
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [3:0]      ctl,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal
);

  // Operation select; unknown codes yield a zero result tagged illegal.
  always_comb begin
    result  = {XLEN{1'b0}};
    illegal = 1'b0;
    case (ctl)
      ALU_CTL_AND: result = a & b;
      ALU_CTL_OR:  result = a | b;
      ALU_CTL_ADD: result = a + b;
      ALU_CTL_SUB: result = a - b;
      default: begin
        result  = {XLEN{1'b0}};
        illegal = 1'b1;
      end
    endcase
  end

  // An illegal op must not look like a taken beq, so zero is masked.
  assign zero = !illegal && (result == {XLEN{1'b0}});

endmodule

// File: rtl/alu_exec_unit.sv
// -----------------------------------------------------------------------------
// alu_exec_unit
// Two-stage execute unit between ID/EX and EX/MEM. S1 registers the accepted
// op and operands; S2 evaluates alu_core on S1 contents and registers the
// result, zero flag and illegal tag. Valid/ready on both sides, 1 op/cycle
// when unstalled, at most 2 ops held under backpressure.
// Ports:
//   clk         in   1     rising-edge clock
//   reset       in   1     synchronous active-high reset
//   in_valid    in   1     upstream presents an op
//   in_ready    out  1     op accepted this cycle (depends on out_ready, not in_valid)
//   alu_ctl     in   4     ALU control code
//   op_a, op_b  in   XLEN  operands
//   out_valid   out  1     result present
//   out_ready   in   1     downstream consumes result
//   result      out  XLEN  ALU result
//   zero        out  1     result == 0 (beq resolution)
//   illegal     out  1     result came from an illegal alu_ctl
//   err_sticky  out  1     any illegal op was accepted since reset
// -----------------------------------------------------------------------------
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_ctl,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal,
  output logic            err_sticky
);

  logic            s1_valid_r;
  logic [3:0]      s1_ctl_r;
  logic [XLEN-1:0] s1_a_r;
  logic [XLEN-1:0] s1_b_r;

  logic            s2_valid_r;
  logic [XLEN-1:0] result_r;
  logic            zero_r;
  logic            illegal_r;
  logic            err_sticky_r;

  logic            s2_load_s;
  logic            s1_advance_s;
  logic            s1_load_s;

  logic [XLEN-1:0] core_result_s;
  logic            core_zero_s;
  logic            core_illegal_s;

  // S2 can take new contents when empty or when its current result leaves.
  assign s2_load_s    = !s2_valid_r || out_ready;
  assign s1_advance_s = s1_valid_r && s2_load_s;
  // Ready is held low during reset so nothing is accepted on a reset cycle.
  assign in_ready     = !reset && (!s1_valid_r || s1_advance_s);
  assign s1_load_s    = in_valid && in_ready;

  alu_core #(
    .XLEN (XLEN)
  ) u_alu_core (
    .ctl     (s1_ctl_r),
    .a       (s1_a_r),
    .b       (s1_b_r),
    .result  (core_result_s),
    .zero    (core_zero_s),
    .illegal (core_illegal_s)
  );

  // S1 operand register: load on accept, empty when it moves on without refill.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_r <= 1'b0;
      s1_ctl_r   <= 4'd0;
      s1_a_r     <= {XLEN{1'b0}};
      s1_b_r     <= {XLEN{1'b0}};
    end else if (s1_load_s) begin
      s1_valid_r <= 1'b1;
      s1_ctl_r   <= alu_ctl;
      s1_a_r     <= op_a;
      s1_b_r     <= op_b;
    end else if (s1_advance_s) begin
      s1_valid_r <= 1'b0;
    end else begin
      s1_valid_r <= s1_valid_r;
    end
  end

  // S2 result register: outputs only change when S2 is free to reload.
  always_ff @(posedge clk) begin
    if (reset) begin
      s2_valid_r <= 1'b0;
      result_r   <= {XLEN{1'b0}};
      zero_r     <= 1'b0;
      illegal_r  <= 1'b0;
    end else if (s2_load_s) begin
      s2_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        result_r  <= core_result_s;
        zero_r    <= core_zero_s;
        illegal_r <= core_illegal_s;
      end
    end
  end

  // Sticky error flag: set at acceptance of an illegal code, cleared by reset only.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_sticky_r <= 1'b0;
    end else if (s1_load_s && !alu_ctl_is_legal(alu_ctl)) begin
      err_sticky_r <= 1'b1;
    end
  end

  assign out_valid  = s2_valid_r;
  assign result     = result_r;
  assign zero       = zero_r;
  assign illegal    = illegal_r;
  assign err_sticky = err_sticky_r;

endmodule

// File: tb/tb_alu_exec_unit.sv
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  alu_ctl = 4'd0;
  logic [31:0] op_a = 32'd0;
  logic [31:0] op_b = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        zero;
  logic        illegal;
  logic        err_sticky;

  alu_exec_unit #(.XLEN(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .alu_ctl    (alu_ctl),
    .op_a       (op_a),
    .op_b       (op_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .zero       (zero),
    .illegal    (illegal),
    .err_sticky (err_sticky)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] r;
    logic        z;
    logic        il;
  } exp_t;

  exp_t q[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  logic err_model = 1'b0;
  logic prev_stalled = 1'b0;
  logic last_acc;
  int   pop_cnt = 0;
  logic [3:0] legal_codes [4] = '{4'd0, 4'd1, 4'd2, 4'd6};

  // Reference: operations defined by plain modular arithmetic on the operands.
  function automatic exp_t model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    longint unsigned la, lb, m;
    la = 64'(a);
    lb = 64'(b);
    m  = 64'd4294967296;
    e.il = 1'b0;
    if (c == 4'd0)      e.r = a & b;
    else if (c == 4'd1) e.r = a | b;
    else if (c == 4'd2) e.r = 32'((la + lb) % m);
    else if (c == 4'd6) e.r = 32'((la + m - lb) % m);
    else begin
      e.r  = 32'd0;
      e.il = 1'b1;
    end
    e.z = !e.il && (e.r == 32'd0);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: check outputs against the model queue, record transfers, advance.
  task automatic step();
    exp_t e;
    #1;
    if (prev_stalled) chk("out_valid_held", 64'(out_valid), 64'd1);
    if (q.size() == 0) begin
      chk("no_stale_out", 64'(out_valid), 64'd0);
    end else if (out_valid) begin
      e = q[0];
      chk("out_data", {29'd0, result, zero, illegal}, {29'd0, e.r, e.z, e.il});
      if (out_ready) begin
        void'(q.pop_front());
        pop_cnt++;
      end
    end
    prev_stalled = out_valid && !out_ready;
    last_acc = in_valid && in_ready;
    if (last_acc) begin
      e = model(alu_ctl, op_a, op_b);
      q.push_back(e);
      if (e.il) err_model = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    chk("err_sticky", 64'(err_sticky), 64'(err_model));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    q.delete();
    err_model = 1'b0;
    prev_stalled = 1'b0;
    #1;
    chk("rst_outputs", {30'd0, out_valid, result, zero, illegal, err_sticky},
        {30'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0});
    chk("rst_release_ready", 64'(in_ready), 64'd1);
  endtask

  task automatic set_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    in_valid = 1'b1;
    alu_ctl  = c;
    op_a     = a;
    op_b     = b;
  endtask

  task automatic set_rand_legal();
    set_op(legal_codes[$urandom_range(0, 3)], $urandom, $urandom);
  endtask

  // Single op into an empty pipe; result expected exactly two edges later.
  task automatic directed(input string tag, input logic [3:0] c, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] er, input logic ez);
    out_ready = 1'b1;
    set_op(c, a, b);
    step();
    in_valid = 1'b0;
    step();
    chk({tag, "_latency"}, 64'(out_valid), 64'd1);
    chk({tag, "_value"}, {31'd0, result, zero}, {31'd0, er, ez});
    step();
  endtask

  initial begin
    int sent;
    int pops0;
    @(negedge clk);
    do_reset();

    // Reset mid-operation, with an illegal op in flight to prove err_sticky clears.
    out_ready = 1'b0;
    set_op(4'd2, 32'd5, 32'd7);
    step();
    set_op(4'd15, 32'd1, 32'd2);
    step();
    in_valid = 1'b0;
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) step();

    // Directed arithmetic and beq path.
    directed("add_wrap", 4'd2, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 1'b0);
    directed("sub_eq",   4'd6, 32'h1234_5678, 32'h1234_5678, 32'h0000_0000, 1'b1);
    directed("and_zero", 4'd0, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 32'h0000_0000, 1'b1);
    directed("or_ones",  4'd1, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 32'hFFFF_FFFF, 1'b0);

    // Backpressure: 4 ADDs, out_ready low for the first 5 cycles.
    sent = 0;
    pops0 = pop_cnt;
    for (int c = 0; c < 14; c++) begin
      out_ready = (c >= 5);
      if (sent < 4) set_op(4'd2, $urandom, $urandom);
      else in_valid = 1'b0;
      if (c >= 2 && c < 5) begin
        #1;
        chk("bp_in_ready_low", 64'(in_ready), 64'd0);
      end
      step();
      if (last_acc) sent++;
    end
    in_valid = 1'b0;
    chk("bp_all_sent", 64'(sent), 64'd4);
    chk("bp_all_out", 64'(pop_cnt - pops0), 64'd4);
    chk("bp_queue_empty", 64'(q.size()), 64'd0);

    // Full throughput: 8 back-to-back random legal ops.
    out_ready = 1'b1;
    pops0 = pop_cnt;
    for (int j = 0; j < 8; j++) begin
      set_rand_legal();
      chk("tp_out_valid", 64'(out_valid), 64'(j >= 2));
      #1;
      chk("tp_in_ready", 64'(in_ready), 64'd1);
      step();
    end
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("tp_drain_valid", 64'(out_valid), 64'(k < 2));
      step();
    end
    chk("tp_count", 64'(pop_cnt - pops0), 64'd8);

    // Illegal op between two ADDs; err_sticky persists over later legal ops.
    set_op(4'd2, $urandom, $urandom);
    step();
    set_op(4'd15, $urandom, $urandom);
    step();
    chk("ill_sticky_set", 64'(err_sticky), 64'd1);
    set_op(4'd2, $urandom, $urandom);
    step();
    in_valid = 1'b0;
    chk("ill_middle_out", {31'd0, out_valid, illegal, result, zero},
        {31'd0, 1'b1, 1'b1, 32'd0, 1'b0});
    for (int k = 0; k < 6; k++) begin
      if (k < 4) set_rand_legal();
      else in_valid = 1'b0;
      step();
    end
    chk("ill_sticky_kept", 64'(err_sticky), 64'd1);
    chk("ill_queue_empty", 64'(q.size()), 64'd0);
    do_reset();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
